// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: loader op_kind codes, primary opcodes,
// R-type funct codes and the loader FSM state encoding.
package mips_isa_pkg;

  // Symbolic operation kinds accepted on the request stream (10-15 illegal)
  typedef enum logic [3:0] {
    KIND_ADD  = 4'd0,
    KIND_SUB  = 4'd1,
    KIND_AND  = 4'd2,
    KIND_OR   = 4'd3,
    KIND_SLT  = 4'd4,
    KIND_LW   = 4'd5,
    KIND_SW   = 4'd6,
    KIND_BEQ  = 4'd7,
    KIND_ADDI = 4'd8,
    KIND_J    = 4'd9
  } op_kind_e;

  // Primary opcodes (bits 31:26)
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_J     = 6'h02;

  // R-type funct codes (bits 5:0)
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Loader session states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational encoder: op_kind plus register/immediate/target fields
// to a 32-bit MIPS word. Unknown kinds produce a NOP and raise illegal.
module instr_field_encoder
  import mips_isa_pkg::*;
(
  input  logic [3:0]  op_kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the instruction format and fixed opcode/funct for each kind
  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    case (op_kind)
      KIND_ADD:  word = {OPC_RTYPE, rs, rt, rd, 5'h00, FN_ADD};
      KIND_SUB:  word = {OPC_RTYPE, rs, rt, rd, 5'h00, FN_SUB};
      KIND_AND:  word = {OPC_RTYPE, rs, rt, rd, 5'h00, FN_AND};
      KIND_OR:   word = {OPC_RTYPE, rs, rt, rd, 5'h00, FN_OR};
      KIND_SLT:  word = {OPC_RTYPE, rs, rt, rd, 5'h00, FN_SLT};
      KIND_LW:   word = {OPC_LW,   rs, rt, imm};
      KIND_SW:   word = {OPC_SW,   rs, rt, imm};
      KIND_BEQ:  word = {OPC_BEQ,  rs, rt, imm};
      KIND_ADDI: word = {OPC_ADDI, rs, rt, imm};
      KIND_J:    word = {OPC_J, target};
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts symbolic requests, encodes them and
// writes consecutive words into instruction memory while holding the core
// in reset. Optional running XOR checksum enabled by LOADER_CHECKSUM_EN.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int unsigned     DEPTH     = 64,
  parameter int unsigned     AW        = 32,
  parameter logic [AW-1:0]   BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [3:0]    op_kind,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [15:0]   imm,
  input  logic [25:0]   target,
  input  logic          last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [31:0]   checksum
);

  localparam int unsigned IW = $clog2(DEPTH) + 1;

  loader_state_e state_q, state_d;
  logic [IW-1:0] index_q, index_d;
  logic          imem_we_q, imem_we_d;
  logic [AW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]   imem_wdata_q, imem_wdata_d;
  logic          error_q, error_d;

  logic [31:0]   enc_word;
  logic          enc_illegal;
  logic          handshake;
  logic          enter_load;
  logic          at_limit;

  instr_field_encoder u_encoder (
    .op_kind (op_kind),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .imm     (imm),
    .target  (target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign op_ready   = (state_q == ST_LOAD);
  assign handshake  = op_valid & op_ready;
  assign enter_load = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign at_limit   = (index_q == IW'(DEPTH - 1));

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign error      = error_q;
  assign done       = (state_q == ST_DONE);
  assign cpu_hold   = (state_q != ST_DONE);

  // Session FSM: next state, write register staging, index and sticky error
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    error_d      = error_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          index_d = '0;
          error_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (handshake) begin
          imem_we_d    = 1'b1;
          imem_wdata_d = enc_word;
          imem_addr_d  = BASE_ADDR + (AW'(index_q) << 2);
          index_d      = index_q + 1'b1;
          if (enc_illegal) begin
            error_d = 1'b1;
          end
          if (last) begin
            state_d = ST_DRAIN;
          end else if (at_limit) begin
            state_d = ST_DRAIN;
            error_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      index_q      <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE_ADDR;
      imem_wdata_q <= 32'h0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      error_q      <= error_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  // Running XOR of every word accepted for writing, cleared on session start
  always_comb begin
    checksum_d = checksum_q;
    if (enter_load) begin
      checksum_d = 32'h0;
    end else if (handshake) begin
      checksum_d = checksum_q ^ enc_word;
    end
  end

  // Checksum accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= 32'h0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: stimulus pushes expected writes
// and status snapshots into queues; a negedge monitor pops and compares.
module tb_instr_encoder_loader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam logic [31:0] BASE  = 32'h0;

  typedef struct {
    int unsigned kind, rs, rt, rd, imm, tgt;
    bit          last;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string       name;
    int          mode;
    logic        rdy, we, hold, dn, err;
    logic [31:0] sum;
    bit          bus;
  } stat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [3:0]    op_kind = '0;
  logic [4:0]    rs = '0, rt = '0, rd = '0;
  logic [15:0]   imm = '0;
  logic [25:0]   target = '0;
  logic          last = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold, done, error;
  logic [31:0]   checksum;

  instr_encoder_loader #(.DEPTH(DEPTH), .AW(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .op_valid(op_valid), .op_ready(op_ready),
    .op_kind(op_kind), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .last(last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  wr_t   wq[$];
  stat_t sq[$];
  int    vectors = 0;
  int    miscompares = 0;

  int          idx;
  bit          expErr;
  logic [31:0] expSum;

  // Reference encoder computed from field positions with plain arithmetic
  function automatic logic [31:0] refEncode(input req_t r, output bit bad);
    int unsigned functTab[5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
    int unsigned opTab[4]    = '{32'h23, 32'h2B, 32'h04, 32'h08};
    int unsigned w;
    bad = 1'b0;
    if (r.kind < 5)
      w = r.rs * 32'h0020_0000 + r.rt * 32'h0001_0000 + r.rd * 32'h800 + functTab[r.kind];
    else if (r.kind < 9)
      w = opTab[r.kind - 5] * 32'h0400_0000 + r.rs * 32'h0020_0000 + r.rt * 32'h0001_0000 + r.imm;
    else if (r.kind == 9)
      w = 2 * 32'h0400_0000 + r.tgt;
    else begin
      w = 0;
      bad = 1'b1;
    end
    return w;
  endfunction

  function automatic logic [31:0] modelSum();
`ifdef LOADER_CHECKSUM_EN
    return expSum;
`else
    return 32'h0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushStatus(input string name, input int mode, input logic rdy, input logic we,
                            input logic hold, input logic dn, input logic err, input bit bus);
    stat_t s;
    s.name = name; s.mode = mode; s.rdy = rdy; s.we = we; s.hold = hold;
    s.dn = dn; s.err = err; s.sum = modelSum(); s.bus = bus;
    sq.push_back(s);
  endtask

  // Monitor: compare every write strobe and any queued status snapshot
  always @(negedge clk) begin
    wr_t   w;
    stat_t s;
    if (imem_we) begin
      if (wq.size() == 0) begin
        checkOutput("spurious_write", {31'b0, imem_we}, 32'd0);
      end else begin
        w = wq.pop_front();
        checkOutput("write_addr", imem_addr, w.addr);
        checkOutput("write_data", imem_wdata, w.data);
      end
    end
    while (sq.size() > 0) begin
      s = sq.pop_front();
      if (s.mode == 2) begin
        checkOutput({s.name, ".pending"}, wq.size(), 32'd0);
      end else if (s.mode == 1) begin
        checkOutput({s.name, ".op_ready"}, {31'b0, op_ready}, {31'b0, s.rdy});
      end else begin
        checkOutput({s.name, ".op_ready"}, {31'b0, op_ready}, {31'b0, s.rdy});
        checkOutput({s.name, ".imem_we"},  {31'b0, imem_we},  {31'b0, s.we});
        checkOutput({s.name, ".cpu_hold"}, {31'b0, cpu_hold}, {31'b0, s.hold});
        checkOutput({s.name, ".done"},     {31'b0, done},     {31'b0, s.dn});
        checkOutput({s.name, ".error"},    {31'b0, error},    {31'b0, s.err});
        checkOutput({s.name, ".checksum"}, checksum, s.sum);
        if (s.bus) begin
          checkOutput({s.name, ".imem_addr"},  imem_addr, BASE);
          checkOutput({s.name, ".imem_wdata"}, imem_wdata, 32'h0);
        end
      end
    end
  end

  task automatic driveReq(input req_t r);
    op_kind = r.kind[3:0]; rs = r.rs[4:0]; rt = r.rt[4:0]; rd = r.rd[4:0];
    imm = r.imm[15:0]; target = r.tgt[25:0]; last = r.last;
    op_valid = 1'b1;
  endtask

  // Offer one request and wait (bounded) for its handshake
  task automatic applyStimulus(input req_t r, input bit alsoStart);
    int          waited = 0;
    bit          bad;
    logic [31:0] word;
    wr_t         w;
    driveReq(r);
    start = alsoStart;
    @(negedge clk);
    while (!op_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!op_ready) begin
      pushStatus("handshake_timeout", 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      op_valid = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    word = refEncode(r, bad);
    w.addr = BASE + 32'(idx) * 4;
    w.data = word;
    wq.push_back(w);
    idx++;
    expErr |= bad;
    expSum ^= word;
    #1;
    op_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic startPulse();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    idx = 0;
    expErr = 1'b0;
    expSum = 32'h0;
    pushStatus("load_entry", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic runSession(input req_t reqs[$], input bit randStart);
    int k = 0;
    startPulse();
    while (k < reqs.size()) begin
      applyStimulus(reqs[k], randStart && k > 0 && $urandom_range(0, 3) == 0);
      k++;
      if (reqs[k-1].last) break;
      if (idx == DEPTH) begin
        expErr = 1'b1;
        break;
      end
    end
    if (k < reqs.size()) driveReq(reqs[k]);
    @(posedge clk);
    #1;
    pushStatus("done_state", 0, 1'b0, 1'b0, 1'b0, 1'b1, expErr, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    op_valid = 1'b0;
    pushStatus("done_hold", 0, 1'b0, 1'b0, 1'b0, 1'b1, expErr, 1'b0);
  endtask

  function automatic req_t mk(int unsigned kind, int unsigned rs_, int unsigned rt_, int unsigned rd_,
                              int unsigned imm_, int unsigned tgt_, bit last_);
    req_t r;
    r.kind = kind; r.rs = rs_; r.rt = rt_; r.rd = rd_; r.imm = imm_; r.tgt = tgt_; r.last = last_;
    return r;
  endfunction

  function automatic req_t randReq(bit last_);
    int unsigned kind;
    if ($urandom_range(0, 4) == 0) kind = $urandom_range(10, 15);
    else kind = $urandom_range(0, 9);
    return mk(kind, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 65535), $urandom & 32'h03FF_FFFF, last_);
  endfunction

  initial begin
    req_t reqs[$];
    int   n;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idx = 0; expErr = 1'b0; expSum = 32'h0;
    pushStatus("after_reset", 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    driveReq(mk(0, 1, 2, 3, 0, 0, 1'b1));
    repeat (3) @(posedge clk);
    #1;
    op_valid = 1'b0;
    pushStatus("idle_ignore", 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    reqs = '{mk(0, 1, 2, 3, 0, 0, 0), mk(5, 0, 2, 0, 4, 0, 0), mk(6, 0, 2, 0, 8, 0, 1)};
    runSession(reqs, 1'b0);

    reqs = '{mk(7, 1, 2, 0, 16'hFFFF, 0, 0), mk(8, 0, 1, 0, 5, 0, 0), mk(9, 0, 0, 0, 0, 26'h10, 1)};
    runSession(reqs, 1'b0);

    reqs = '{mk(12, 3, 4, 5, 16'h1234, 26'h155, 1)};
    runSession(reqs, 1'b0);

    reqs = '{mk(1, 4, 5, 6, 0, 0, 0), mk(2, 7, 8, 9, 0, 0, 0), mk(3, 1, 1, 1, 0, 0, 0),
             mk(4, 2, 3, 4, 0, 0, 0), mk(0, 9, 9, 9, 0, 0, 0)};
    runSession(reqs, 1'b0);

    startPulse();
    applyStimulus(mk(0, 1, 2, 3, 0, 0, 0), 1'b0);
    applyStimulus(mk(8, 5, 6, 0, 16'h00AA, 0, 0), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expErr = 1'b0; expSum = 32'h0;
    pushStatus("mid_reset", 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    for (int s = 0; s < 30; s++) begin
      reqs.delete();
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i <= DEPTH; i++) reqs.push_back(randReq(1'b0));
      end else begin
        n = $urandom_range(1, DEPTH);
        for (int i = 0; i < n; i++) reqs.push_back(randReq(i == n - 1));
      end
      runSession(reqs, 1'b1);
    end

    pushStatus("final", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
